arm_motion_sequencer: RTL and testbench
=======================================

# arm_motion_sequencer

Arbitrates the arm's coordinate requesters (keyboard, ultrasonic, XADC, home) and sequences commanded (x,y) toward the winning target one unit per step period. Its output drives the inverse-kinematics lookup. It also owns the servo enable window: active while moving and for a hold time after arrival, then off so the servos rest on friction. It sits between the input decoders and the IK/PWM datapath, replacing per-axis change-detect enables.

## Interface
- STEP_CYCLES, 1_000_000: clk cycles per one-unit step (100 ms at 10 MHz); must be ≥ 1.
- HOLD_CYCLES, 2_000_000: cycles servo_en stays high after arrival; must be ≥ 1.
- HOME_X, 8'd2: x coordinate for reset and when no source is active.
- HOME_Y, 8'd2: y coordinate for reset and when no source is active.
- clk  in  1  10 MHz clock.
- reset  in  1  synchronous, active-high.
- state  in  2  top-level mode; 2'b11 enables the XADC source.
- kb_req  in  1  keyboard source active.
- kb_x, kb_y  in  8 each  keyboard target.
- us_req  in  1  ultrasonic source active.
- us_x, us_y  in  8 each  ultrasonic target.
- adc_x, adc_y  in  8 each  XADC target.
- cmd_x, cmd_y  out  8 each  commanded coordinate to IK.
- cmd_valid  out  1  one-cycle pulse when cmd_x/cmd_y change by a step.
- servo_en  out  1  PWM enable for both servos.
- busy  out  1  high in MOVE.
- at_target  out  1  cmd equals the registered target.
- active_src  out  2  granted source: 0 home, 1 adc, 2 ultrasonic, 3 keyboard.

## Operation
- Fixed priority: kb_req > us_req > (state==2'b11 → adc) > home.
- Each cycle, the winner's (x,y) and its code are registered into target_x/target_y/active_src.
- Stepping: unsigned 8-bit. Each axis moves ±1 toward target, or holds if equal. Both axes step on the same cycle (diagonal). Steps never wrap: 0 and 255 are reached exactly.
- FSM states IDLE, MOVE, HOLD. Each transition below is evaluated at a clock edge:
  - IDLE: if target≠cmd → MOVE, timer=0.
  - MOVE: timer increments each cycle.
    - At timer==STEP_CYCLES-1: apply step, pulse cmd_valid, timer=0.
    - If the stepped cmd equals target → HOLD, hold=0.
    - If target becomes equal to cmd without a step → HOLD, no pulse.
  - HOLD: hold increments each cycle.
    - Target≠cmd → MOVE, timer=0. This takes precedence over expiry.
    - hold==HOLD_CYCLES-1 → IDLE.
- The target may change at any time. Each step uses the target registered on that cycle, so retargeting mid-move redirects the path with no restart of the timer.
- servo_en = (fsm≠IDLE), busy = (fsm==MOVE); both registered.
- at_target is combinational compare of registered cmd and target.

## Timing
- Reset values:
  - cmd = target = (HOME_X, HOME_Y)
  - fsm = IDLE, timer = hold = 0
  - cmd_valid = 0, servo_en = 0, busy = 0, active_src = 0, at_target = 1
- Reset mid-MOVE or mid-HOLD: cmd snaps to home on the next edge. No ramp, no cmd_valid.
- Source change at edge N: target updates at N+1, MOVE is entered at N+2, first step is registered at N+2+STEP_CYCLES.
- Subsequent steps follow every STEP_CYCLES cycles.
- cmd_valid is high exactly on the cycle after each step edge, for 1 cycle.
- servo_en falls HOLD_CYCLES cycles after HOLD entry, unless retargeted.

## Structure
- Package motion_pkg holds:
  - fsm enum {IDLE, MOVE, HOLD}
  - SRC_HOME/SRC_ADC/SRC_US/SRC_KB constants
  - default home coordinate constants
- Sub-module coord_source_select: combinational priority mux. Outputs winner x, y and src code.
- Timers are sized with $clog2 of their parameters.

## Test plan
All scenarios use STEP_CYCLES=4, HOLD_CYCLES=8.
- Reset held 3 cycles → cmd=(2,2), servo_en=0, busy=0, active_src=0, cmd_valid never high.
- kb_req=1, kb=(5,2) → active_src=3, cmd_x steps 3,4,5 at 4-cycle spacing, exactly 3 cmd_valid pulses, then servo_en high 8 more cycles and falls.
- kb_req and us_req both high, us=(9,9), kb=(2,4) → follows keyboard; drop kb_req → active_src=2 and the path redirects to (9,9) without a timer restart.
- Retarget at cmd=(4,4) from target (10,10) to (3,6) → next cmds (3,5), (3,6), then HOLD.
- state=2'b11, adc=(0,4), no reqs → cmd (1,3), (0,4), then stays at x=0 with no underflow.
- adc=(255,2) → x reaches 255 and stays there with no wrap.
- Reset asserted in MOVE at cmd=(4,3) → next cycle cmd=(2,2), fsm IDLE, no cmd_valid.
- Retarget in HOLD at hold=5 → re-enters MOVE and servo_en stays continuously high.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared types, source codes and the per-axis step helper for the arm motion sequencer.
package motion_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HOLD = 2'd2
  } fsm_e;

  localparam logic [1:0] SRC_HOME  = 2'd0;
  localparam logic [1:0] SRC_ADC   = 2'd1;
  localparam logic [1:0] SRC_US    = 2'd2;
  localparam logic [1:0] SRC_KB    = 2'd3;
  localparam logic [1:0] STATE_ADC = 2'b11;

  localparam logic [7:0] DEF_HOME_X = 8'd2;
  localparam logic [7:0] DEF_HOME_Y = 8'd2;

  // Moves one unit toward tgt; holding on equality is what keeps 0 and 255 from wrapping.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] nxt;
    if (cur < tgt) begin
      nxt = cur + 8'd1;
    end else if (cur > tgt) begin
      nxt = cur - 8'd1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/arm_motion_sequencer_coord_source_select.sv
// Fixed-priority coordinate mux: keyboard > ultrasonic > XADC (mode 2'b11) > home.
module coord_source_select
  import motion_pkg::*;
#(
  parameter logic [7:0] HOME_X = DEF_HOME_X,
  parameter logic [7:0] HOME_Y = DEF_HOME_Y
) (
  input  logic [1:0] state,
  input  logic       kb_req,
  input  logic [7:0] kb_x,
  input  logic [7:0] kb_y,
  input  logic       us_req,
  input  logic [7:0] us_x,
  input  logic [7:0] us_y,
  input  logic [7:0] adc_x,
  input  logic [7:0] adc_y,
  output logic [7:0] win_x,
  output logic [7:0] win_y,
  output logic [1:0] win_src
);

  // Pick the highest-priority active requester.
  always_comb begin
    win_x   = HOME_X;
    win_y   = HOME_Y;
    win_src = SRC_HOME;
    if (kb_req) begin
      win_x   = kb_x;
      win_y   = kb_y;
      win_src = SRC_KB;
    end else if (us_req) begin
      win_x   = us_x;
      win_y   = us_y;
      win_src = SRC_US;
    end else if (state == STATE_ADC) begin
      win_x   = adc_x;
      win_y   = adc_y;
      win_src = SRC_ADC;
    end else begin
      win_x   = HOME_X;
      win_y   = HOME_Y;
      win_src = SRC_HOME;
    end
  end

endmodule

// File: rtl/arm_motion_sequencer.sv
// Arbitrates coordinate requesters and ramps the commanded (x,y) one unit per step period,
// keeping the servo enable window open while moving and for a hold time after arrival.
module arm_motion_sequencer
  import motion_pkg::*;
#(
  parameter int         STEP_CYCLES = 1_000_000,
  parameter int         HOLD_CYCLES = 2_000_000,
  parameter logic [7:0] HOME_X      = DEF_HOME_X,
  parameter logic [7:0] HOME_Y      = DEF_HOME_Y
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] state,
  input  logic       kb_req,
  input  logic [7:0] kb_x,
  input  logic [7:0] kb_y,
  input  logic       us_req,
  input  logic [7:0] us_x,
  input  logic [7:0] us_y,
  input  logic [7:0] adc_x,
  input  logic [7:0] adc_y,
  output logic [7:0] cmd_x,
  output logic [7:0] cmd_y,
  output logic       cmd_valid,
  output logic       servo_en,
  output logic       busy,
  output logic       at_target,
  output logic [1:0] active_src
);

  localparam int TIMER_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] STEP_LAST = TIMER_W'(STEP_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [7:0]         win_x, win_y;
  logic [1:0]         win_src;
  logic [7:0]         target_x_q, target_y_q;
  logic [1:0]         active_src_q;
  logic [7:0]         cmd_x_q, cmd_x_d, cmd_y_q, cmd_y_d;
  logic [7:0]         stepped_x, stepped_y;
  fsm_e               fsm_q, fsm_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               servo_en_q, servo_en_d;
  logic               busy_q, busy_d;

  coord_source_select #(
    .HOME_X (HOME_X),
    .HOME_Y (HOME_Y)
  ) u_select (
    .state   (state),
    .kb_req  (kb_req),
    .kb_x    (kb_x),
    .kb_y    (kb_y),
    .us_req  (us_req),
    .us_x    (us_x),
    .us_y    (us_y),
    .adc_x   (adc_x),
    .adc_y   (adc_y),
    .win_x   (win_x),
    .win_y   (win_y),
    .win_src (win_src)
  );

  assign at_target = (cmd_x_q == target_x_q) && (cmd_y_q == target_y_q);
  assign stepped_x = step_toward(cmd_x_q, target_x_q);
  assign stepped_y = step_toward(cmd_y_q, target_y_q);

  // Next-state logic; a changed target in HOLD wins over hold expiry.
  always_comb begin
    fsm_d       = fsm_q;
    timer_d     = timer_q;
    hold_d      = hold_q;
    cmd_x_d     = cmd_x_q;
    cmd_y_d     = cmd_y_q;
    cmd_valid_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (!at_target) begin
          fsm_d   = MOVE;
          timer_d = '0;
        end else begin
          fsm_d = IDLE;
        end
      end
      MOVE: begin
        if (at_target) begin
          fsm_d  = HOLD;
          hold_d = '0;
        end else if (timer_q == STEP_LAST) begin
          cmd_x_d     = stepped_x;
          cmd_y_d     = stepped_y;
          cmd_valid_d = 1'b1;
          timer_d     = '0;
          if ((stepped_x == target_x_q) && (stepped_y == target_y_q)) begin
            fsm_d  = HOLD;
            hold_d = '0;
          end else begin
            fsm_d = MOVE;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      HOLD: begin
        if (!at_target) begin
          fsm_d   = MOVE;
          timer_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          fsm_d = IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
    servo_en_d = (fsm_d != IDLE);
    busy_d     = (fsm_d == MOVE);
  end

  // State, target and output registers; reset snaps everything home with no ramp.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_x_q   <= HOME_X;
      target_y_q   <= HOME_Y;
      active_src_q <= SRC_HOME;
      cmd_x_q      <= HOME_X;
      cmd_y_q      <= HOME_Y;
      fsm_q        <= IDLE;
      timer_q      <= '0;
      hold_q       <= '0;
      cmd_valid_q  <= 1'b0;
      servo_en_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      target_x_q   <= win_x;
      target_y_q   <= win_y;
      active_src_q <= win_src;
      cmd_x_q      <= cmd_x_d;
      cmd_y_q      <= cmd_y_d;
      fsm_q        <= fsm_d;
      timer_q      <= timer_d;
      hold_q       <= hold_d;
      cmd_valid_q  <= cmd_valid_d;
      servo_en_q   <= servo_en_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd_x      = cmd_x_q;
  assign cmd_y      = cmd_y_q;
  assign cmd_valid  = cmd_valid_q;
  assign servo_en   = servo_en_q;
  assign busy       = busy_q;
  assign active_src = active_src_q;

endmodule

// File: tb/tb_arm_motion_sequencer.sv
// Self-checking bench for arm_motion_sequencer: directed scenarios plus randomized traffic
// compared against a behavioural model of the stepping and enable-window rules.
module tb_arm_motion_sequencer;

  localparam int STEP = 4;
  localparam int HOLD = 8;

  logic       clk, reset;
  logic [1:0] state;
  logic       kb_req, us_req;
  logic [7:0] kb_x, kb_y, us_x, us_y, adc_x, adc_y;
  logic [7:0] cmd_x, cmd_y;
  logic       cmd_valid, servo_en, busy, at_target;
  logic [1:0] active_src;

  int checks = 0;
  int errors = 0;

  arm_motion_sequencer #(
    .STEP_CYCLES (STEP),
    .HOLD_CYCLES (HOLD),
    .HOME_X      (8'd2),
    .HOME_Y      (8'd2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .state      (state),
    .kb_req     (kb_req),
    .kb_x       (kb_x),
    .kb_y       (kb_y),
    .us_req     (us_req),
    .us_x       (us_x),
    .us_y       (us_y),
    .adc_x      (adc_x),
    .adc_y      (adc_y),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_valid  (cmd_valid),
    .servo_en   (servo_en),
    .busy       (busy),
    .at_target  (at_target),
    .active_src (active_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: countdown/elapsed integers rather than a state encoding.
  int m_cx, m_cy, m_tx, m_ty, m_src, m_elapsed, m_hold_left;
  bit m_valid, m_moving;

  always @(posedge clk) begin : ref_model
    int nx, ny, el, hl, wx, wy, ws;
    bit mv, vl, eq;
    if (reset) begin
      m_cx <= 2; m_cy <= 2; m_tx <= 2; m_ty <= 2; m_src <= 0;
      m_elapsed <= 0; m_hold_left <= 0; m_moving <= 1'b0; m_valid <= 1'b0;
    end else begin
      nx = m_cx; ny = m_cy; el = m_elapsed; hl = m_hold_left; mv = m_moving; vl = 1'b0;
      eq = (m_cx == m_tx) && (m_cy == m_ty);
      if (m_moving) begin
        if (eq) begin
          mv = 1'b0; hl = HOLD;
        end else if (m_elapsed == STEP - 1) begin
          nx = m_cx + ((m_tx > m_cx) ? 1 : 0) - ((m_tx < m_cx) ? 1 : 0);
          ny = m_cy + ((m_ty > m_cy) ? 1 : 0) - ((m_ty < m_cy) ? 1 : 0);
          vl = 1'b1; el = 0;
          if (nx == m_tx && ny == m_ty) begin mv = 1'b0; hl = HOLD; end
        end else begin
          el = m_elapsed + 1;
        end
      end else if (m_hold_left > 0) begin
        if (!eq) begin mv = 1'b1; el = 0; hl = 0; end
        else hl = m_hold_left - 1;
      end else if (!eq) begin
        mv = 1'b1; el = 0;
      end
      if (kb_req) begin wx = kb_x; wy = kb_y; ws = 3; end
      else if (us_req) begin wx = us_x; wy = us_y; ws = 2; end
      else if (state == 2'b11) begin wx = adc_x; wy = adc_y; ws = 1; end
      else begin wx = 2; wy = 2; ws = 0; end
      m_cx <= nx; m_cy <= ny; m_tx <= wx; m_ty <= wy; m_src <= ws;
      m_elapsed <= el; m_hold_left <= hl; m_moving <= mv; m_valid <= vl;
    end
  end

  task automatic clear_inputs;
    state = 2'b00; kb_req = 1'b0; us_req = 1'b0;
    kb_x = 8'd0; kb_y = 8'd0; us_x = 8'd0; us_y = 8'd0; adc_x = 8'd0; adc_y = 8'd0;
  endtask

  // Called on a falling edge; leaves reset released just before the next rising edge.
  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_inputs();
    kb_req = 1'b1; kb_x = 8'd7; kb_y = 8'd7; state = 2'b11; adc_x = 8'd9; adc_y = 8'd9;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if ({cmd_x, cmd_y} !== {8'd2, 8'd2} || servo_en !== 1'b0 || busy !== 1'b0 ||
          active_src !== 2'd0 || cmd_valid !== 1'b0 || at_target !== 1'b1) begin
        errors++;
        $display("FAIL reset_state k=%0d: got cmd=(%0d,%0d) valid=%b en=%b busy=%b src=%0d at=%b, expected (2,2) 0 0 0 0 1",
                 k, cmd_x, cmd_y, cmd_valid, servo_en, busy, active_src, at_target);
      end
    end
    reset = 1'b0;
    clear_inputs();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({cmd_x, cmd_y} !== {8'd2, 8'd2} || servo_en !== 1'b0 || cmd_valid !== 1'b0 || at_target !== 1'b1) begin
        errors++;
        $display("FAIL idle_after_reset k=%0d: got cmd=(%0d,%0d) valid=%b en=%b at=%b, expected (2,2) 0 0 1",
                 k, cmd_x, cmd_y, cmd_valid, servo_en, at_target);
      end
    end
  endtask

  task automatic test_kb_step;
    int pk[$];
    int px[$];
    do_reset();
    kb_req = 1'b1; kb_x = 8'd5; kb_y = 8'd2;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) begin pk.push_back(k); px.push_back(int'(cmd_x)); end
      if (k == 1) begin
        checks++;
        if (active_src !== 2'd3) begin errors++; $display("FAIL kb_src: got %0d expected 3", active_src); end
      end
      if (k == 13) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL kb_busy_moving: got %b expected 1", busy); end
      end
      if (k == 14) begin
        checks++;
        if ({cmd_x, cmd_y} !== {8'd5, 8'd2} || busy !== 1'b0 || servo_en !== 1'b1) begin
          errors++; $display("FAIL kb_arrive: got cmd=(%0d,%0d) busy=%b en=%b expected (5,2) 0 1", cmd_x, cmd_y, busy, servo_en);
        end
      end
      if (k == 21) begin
        checks++;
        if (servo_en !== 1'b1) begin errors++; $display("FAIL kb_hold_window: got en=%b expected 1", servo_en); end
      end
      if (k == 22) begin
        checks++;
        if (servo_en !== 1'b0) begin errors++; $display("FAIL kb_hold_expire: got en=%b expected 0", servo_en); end
      end
    end
    checks++;
    if (pk.size() != 3) begin errors++; $display("FAIL kb_pulse_count: got %0d expected 3", pk.size()); end
    for (int i = 0; i < pk.size() && i < 3; i++) begin
      checks++;
      if (pk[i] != 6 + 4 * i || px[i] != 3 + i) begin
        errors++; $display("FAIL kb_pulse_%0d: got cycle %0d x=%0d expected cycle %0d x=%0d", i, pk[i], px[i], 6 + 4 * i, 3 + i);
      end
    end
  endtask

  task automatic test_priority;
    do_reset();
    kb_req = 1'b1; kb_x = 8'd2; kb_y = 8'd4;
    us_req = 1'b1; us_x = 8'd9; us_y = 8'd9;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 6) begin
        checks++;
        if ({cmd_x, cmd_y} !== {8'd2, 8'd3} || cmd_valid !== 1'b1 || active_src !== 2'd3) begin
          errors++; $display("FAIL prio_kb_step: got cmd=(%0d,%0d) valid=%b src=%0d expected (2,3) 1 3", cmd_x, cmd_y, cmd_valid, active_src);
        end
      end
      if (k == 7) kb_req = 1'b0;
      if (k == 8) begin
        checks++;
        if (active_src !== 2'd2) begin errors++; $display("FAIL prio_us_src: got %0d expected 2", active_src); end
      end
      if (k == 9) begin
        checks++;
        if ({cmd_x, cmd_y} !== {8'd2, 8'd3} || cmd_valid !== 1'b0) begin
          errors++; $display("FAIL prio_no_early_step: got cmd=(%0d,%0d) valid=%b expected (2,3) 0", cmd_x, cmd_y, cmd_valid);
        end
      end
      if (k == 10) begin
        checks++;
        if ({cmd_x, cmd_y} !== {8'd3, 8'd4} || cmd_valid !== 1'b1) begin
          errors++; $display("FAIL prio_redirect: got cmd=(%0d,%0d) valid=%b expected (3,4) 1", cmd_x, cmd_y, cmd_valid);
        end
      end
      if (k == 34) begin
        checks++;
        if ({cmd_x, cmd_y} !== {8'd9, 8'd9} || busy !== 1'b0 || servo_en !== 1'b1) begin
          errors++; $display("FAIL prio_arrive: got cmd=(%0d,%0d) busy=%b en=%b expected (9,9) 0 1", cmd_x, cmd_y, busy, servo_en);
        end
      end
    end
  endtask

  task automatic test_retarget;
    do_reset();
    kb_req = 1'b1; kb_x = 8'd10; kb_y = 8'd10;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 10) begin
        checks++;
        if ({cmd_x, cmd_y} !== {8'd4, 8'd4}) begin
          errors++; $display("FAIL retarget_start: got cmd=(%0d,%0d) expected (4,4)", cmd_x, cmd_y);
        end
        kb_x = 8'd3; kb_y = 8'd6;
      end
      if (k == 13) begin
        checks++;
        if ({cmd_x, cmd_y} !== {8'd4, 8'd4} || cmd_valid !== 1'b0) begin
          errors++; $display("FAIL retarget_wait: got cmd=(%0d,%0d) valid=%b expected (4,4) 0", cmd_x, cmd_y, cmd_valid);
        end
      end
      if (k == 14) begin
        checks++;
        if ({cmd_x, cmd_y} !== {8'd3, 8'd5} || cmd_valid !== 1'b1) begin
          errors++; $display("FAIL retarget_step1: got cmd=(%0d,%0d) valid=%b expected (3,5) 1", cmd_x, cmd_y, cmd_valid);
        end
      end
      if (k == 18) begin
        checks++;
        if ({cmd_x, cmd_y} !== {8'd3, 8'd6} || cmd_valid !== 1'b1 || busy !== 1'b0 || servo_en !== 1'b1) begin
          errors++; $display("FAIL retarget_step2: got cmd=(%0d,%0d) valid=%b busy=%b en=%b expected (3,6) 1 0 1",
                             cmd_x, cmd_y, cmd_valid, busy, servo_en);
        end
      end
    end
  endtask

  task automatic test_adc_floor;
    int late;
    late = 0;
    do_reset();
    state = 2'b11; adc_x = 8'd0; adc_y = 8'd4;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k > 10 && cmd_valid === 1'b1) late++;
      if (k == 6) begin
        checks++;
        if ({cmd_x, cmd_y} !== {8'd1, 8'd3} || active_src !== 2'd1) begin
          errors++; $display("FAIL adc_step1: got cmd=(%0d,%0d) src=%0d expected (1,3) 1", cmd_x, cmd_y, active_src);
        end
      end
      if (k == 10) begin
        checks++;
        if ({cmd_x, cmd_y} !== {8'd0, 8'd4} || busy !== 1'b0) begin
          errors++; $display("FAIL adc_step2: got cmd=(%0d,%0d) busy=%b expected (0,4) 0", cmd_x, cmd_y, busy);
        end
      end
    end
    checks++;
    if ({cmd_x, cmd_y} !== {8'd0, 8'd4} || late != 0 || servo_en !== 1'b0 || at_target !== 1'b1) begin
      errors++; $display("FAIL adc_floor_rest: got cmd=(%0d,%0d) extra_pulses=%0d en=%b at=%b expected (0,4) 0 0 1",
                         cmd_x, cmd_y, late, servo_en, at_target);
    end
  endtask

  task automatic test_adc_ceiling;
    int pulses, drops;
    logic [7:0] prev;
    pulses = 0; drops = 0;
    do_reset();
    prev = 8'd2;
    state = 2'b11; adc_x = 8'd255; adc_y = 8'd2;
    for (int k = 1; k <= 1060; k++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) pulses++;
      if (cmd_x < prev) drops++;
      prev = cmd_x;
      if (k == 1013) begin
        checks++;
        if (cmd_x !== 8'd254) begin errors++; $display("FAIL adc_ceiling_pre: got x=%0d expected 254", cmd_x); end
      end
      if (k == 1014) begin
        checks++;
        if (cmd_x !== 8'd255 || cmd_valid !== 1'b1 || at_target !== 1'b1) begin
          errors++; $display("FAIL adc_ceiling_reach: got x=%0d valid=%b at=%b expected 255 1 1", cmd_x, cmd_valid, at_target);
        end
      end
    end
    checks++;
    if (pulses != 253 || drops != 0 || cmd_x !== 8'd255 || servo_en !== 1'b0) begin
      errors++; $display("FAIL adc_ceiling_rest: got pulses=%0d drops=%0d x=%0d en=%b expected 253 0 255 0",
                         pulses, drops, cmd_x, servo_en);
    end
  endtask

  task automatic test_reset_mid_move;
    do_reset();
    kb_req = 1'b1; kb_x = 8'd6; kb_y = 8'd3;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    checks++;
    if ({cmd_x, cmd_y} !== {8'd4, 8'd3} || busy !== 1'b1 || cmd_valid !== 1'b1) begin
      errors++; $display("FAIL midmove_pre: got cmd=(%0d,%0d) busy=%b valid=%b expected (4,3) 1 1", cmd_x, cmd_y, busy, cmd_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_x, cmd_y} !== {8'd2, 8'd2} || busy !== 1'b0 || servo_en !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL midmove_reset: got cmd=(%0d,%0d) busy=%b en=%b valid=%b expected (2,2) 0 0 0",
                         cmd_x, cmd_y, busy, servo_en, cmd_valid);
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_hold_retarget;
    int lows;
    lows = 0;
    do_reset();
    kb_req = 1'b1; kb_x = 8'd4; kb_y = 8'd2;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 32 && servo_en !== 1'b1) lows++;
      if (k == 15) kb_x = 8'd6;
      if (k == 16) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL hold_retarget_hold: got busy=%b expected 0", busy); end
      end
      if (k == 17) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL hold_retarget_move: got busy=%b expected 1", busy); end
      end
      if (k == 21) begin
        checks++;
        if ({cmd_x, cmd_y} !== {8'd5, 8'd2} || cmd_valid !== 1'b1) begin
          errors++; $display("FAIL hold_retarget_step: got cmd=(%0d,%0d) valid=%b expected (5,2) 1", cmd_x, cmd_y, cmd_valid);
        end
      end
      if (k == 33) begin
        checks++;
        if ({cmd_x, cmd_y} !== {8'd6, 8'd2} || servo_en !== 1'b0) begin
          errors++; $display("FAIL hold_retarget_end: got cmd=(%0d,%0d) en=%b expected (6,2) 0", cmd_x, cmd_y, servo_en);
        end
      end
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL hold_retarget_window: got %0d low cycles expected 0", lows); end
  endtask

  function automatic logic [7:0] rand_coord();
    int r;
    r = $urandom_range(0, 39);
    if (r == 0) return 8'd0;
    else if (r == 1) return 8'd255;
    else return 8'($urandom_range(0, 15));
  endfunction

  task automatic test_random;
    int seg_left;
    logic [23:0] exp_v, got_v;
    seg_left = 0;
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      if (seg_left == 0) begin
        kb_req = ($urandom_range(0, 2) == 0); us_req = ($urandom_range(0, 2) == 0);
        state = 2'($urandom_range(0, 3));
        kb_x = rand_coord(); kb_y = rand_coord(); us_x = rand_coord(); us_y = rand_coord();
        adc_x = rand_coord(); adc_y = rand_coord();
        seg_left = $urandom_range(1, 80);
      end
      seg_left--;
      reset = ($urandom_range(0, 599) == 0);
      @(negedge clk);
      exp_v = {8'(m_cx), 8'(m_cy), m_valid, (m_moving || m_hold_left > 0), m_moving,
               ((m_cx == m_tx) && (m_cy == m_ty)), 2'(m_src)};
      got_v = {cmd_x, cmd_y, cmd_valid, servo_en, busy, at_target, active_src};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        if (errors <= 20)
          $display("FAIL random c=%0d: got cmd=(%0d,%0d) valid=%b en=%b busy=%b at=%b src=%0d expected cmd=(%0d,%0d) valid=%b en=%b busy=%b at=%b src=%0d",
                   c, got_v[23:16], got_v[15:8], got_v[7], got_v[6], got_v[5], got_v[4], got_v[3:0],
                   exp_v[23:16], exp_v[15:8], exp_v[7], exp_v[6], exp_v[5], exp_v[4], exp_v[3:0]);
      end
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_kb_step();
    test_priority();
    test_retarget();
    test_adc_floor();
    test_adc_ceiling();
    test_reset_mid_move();
    test_hold_retarget();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
